// File: rtl/bt656_pkg.sv
// Shared BT.656 definitions: preamble bytes, XY bit layout, FSM states and
// the protection-bit function used by both receiver and code generator.
package bt656_pkg;

  localparam logic [7:0] PRE_FF = 8'hFF;
  localparam logic [7:0] PRE_00 = 8'h00;

  // XY = {1, F, V, H, P3, P2, P1, P0}
  localparam int XY_ONE = 7;
  localparam int XY_F   = 6;
  localparam int XY_V   = 5;
  localparam int XY_H   = 4;

  typedef enum logic [2:0] {
    S_SEARCH = 3'd0,
    S_P1     = 3'd1,
    S_P2     = 3'd2,
    S_P3     = 3'd3,
    S_DATA   = 3'd4
  } state_t;

  // Protection nibble {P3,P2,P1,P0} for a given F/V/H
  function automatic logic [3:0] bt656_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_xy_check.sv
// Combinational XY decode and protection check; shared with the TX side.
module bt656_xy_check
  import bt656_pkg::*;
(
  input  logic [7:0] xy,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       ok
);

  assign f  = xy[XY_F];
  assign v  = xy[XY_V];
  assign h  = xy[XY_H];
  assign ok = xy[XY_ONE] & (xy[3:0] == bt656_prot(xy[XY_F], xy[XY_V], xy[XY_H]));

endmodule

// File: rtl/bt656_rx.sv
// BT.656 receiver: locks to SAV/EAV timing codes, tracks H/V/F and line
// counts, and unpacks Cb-Y0-Cr-Y1 quads into 32-bit pixel-pair words.
module bt656_rx
  import bt656_pkg::*;
#(
  parameter int ACTIVE_PAIRS = 360,
  parameter int LINE_W       = 10,
  parameter int PAIR_W       = 9
) (
  input  logic              clk_59m,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic [31:0]       pix_data,
  output logic              pix_valid,
  output logic              active,
  output logic              hs,
  output logic              vs,
  output logic              field,
  output logic [LINE_W-1:0] line_cnt,
  output logic [PAIR_W-1:0] pair_cnt,
  output logic              locked,
  output logic              code_err,
  output logic              ovf_err
);

  state_t      state, state_nxt;
  logic        xy_f, xy_v, xy_h, xy_ok;
  logic        cap, code_ok, code_bad;
  logic [1:0]  phase;
  logic [7:0]  cb_q, y0_q, cr_q;

  bt656_xy_check u_xy (
    .xy (din),
    .f  (xy_f),
    .v  (xy_v),
    .h  (xy_h),
    .ok (xy_ok)
  );

  // Timing-code state register
  always_ff @(posedge clk_59m or posedge rst) begin
    if (rst) state <= S_SEARCH;
    else     state <= state_nxt;
  end

  // Next state and per-byte actions; nothing moves without din_valid
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    code_ok   = 1'b0;
    code_bad  = 1'b0;
    if (din_valid) begin
      unique case (state)
        S_SEARCH: if (din == PRE_FF) state_nxt = S_P1;
        S_P1: begin
          if (din == PRE_00)      state_nxt = S_P2;
          else if (din == PRE_FF) state_nxt = S_P1;
          else                    state_nxt = locked ? S_DATA : S_SEARCH;
        end
        S_P2: begin
          if (din == PRE_00)      state_nxt = S_P3;
          else if (din == PRE_FF) state_nxt = S_P1;
          else                    state_nxt = locked ? S_DATA : S_SEARCH;
        end
        S_P3: begin
          if (xy_ok) begin
            code_ok   = 1'b1;
            state_nxt = xy_h ? S_SEARCH : S_DATA;
          end else begin
            code_bad  = 1'b1;
            state_nxt = S_SEARCH;
          end
        end
        S_DATA: begin
          if (din == PRE_FF) state_nxt = S_P1;
          else               cap = 1'b1;
        end
        default: state_nxt = S_SEARCH;
      endcase
    end
  end

  // Sample capture and pair emission; any non-captured byte restarts the quad
  always_ff @(posedge clk_59m or posedge rst) begin
    if (rst) begin
      phase     <= 2'd0;
      cb_q      <= 8'd0;
      y0_q      <= 8'd0;
      cr_q      <= 8'd0;
      pix_data  <= 32'd0;
      pix_valid <= 1'b0;
      pair_cnt  <= '0;
      ovf_err   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      ovf_err   <= 1'b0;
      if (din_valid) begin
        if (cap) begin
          phase <= phase + 2'd1;
          unique case (phase)
            2'd0: cb_q <= din;
            2'd1: y0_q <= din;
            2'd2: cr_q <= din;
            2'd3: begin
              if (active) begin
                if (pair_cnt == PAIR_W'(ACTIVE_PAIRS)) begin
                  ovf_err <= 1'b1;
                end else begin
                  pix_data  <= {cb_q, y0_q, cr_q, din};
                  pix_valid <= 1'b1;
                  pair_cnt  <= pair_cnt + 1'b1;
                end
              end
            end
            default: ;
          endcase
        end else begin
          phase <= 2'd0;
        end
        if (code_ok && !xy_h) pair_cnt <= '0;
      end
    end
  end

  // Timing recovery from valid codes; error handling on bad protection
  always_ff @(posedge clk_59m or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      hs       <= 1'b0;
      vs       <= 1'b0;
      field    <= 1'b0;
      line_cnt <= '0;
      locked   <= 1'b0;
      code_err <= 1'b0;
    end else begin
      hs       <= 1'b0;
      code_err <= 1'b0;
      if (din_valid) begin
        if (code_bad) begin
          code_err <= 1'b1;
          locked   <= 1'b0;
        end
        if (code_ok) begin
          locked <= 1'b1;
          vs     <= xy_v;
          field  <= xy_f;
          // New field or end of vertical blanking restarts the line index
          if ((vs && !xy_v) || (field != xy_f))
            line_cnt <= '0;
          else if (xy_h && active && (line_cnt != '1))
            line_cnt <= line_cnt + 1'b1;
          if (xy_h) begin
            hs     <= 1'b1;
            active <= 1'b0;
          end else begin
            active <= ~xy_v;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bt656_rx.sv
// Directed/randomized bench for bt656_rx with a transaction-level model.
`timescale 1ns/1ps
module tb_bt656_rx;

  logic        clk_59m = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid, active, hs, vs, field, locked, code_err, ovf_err;
  logic [9:0]  line_cnt;
  logic [8:0]  pair_cnt;

  bt656_rx dut (
    .clk_59m   (clk_59m),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .active    (active),
    .hs        (hs),
    .vs        (vs),
    .field     (field),
    .line_cnt  (line_cnt),
    .pair_cnt  (pair_cnt),
    .locked    (locked),
    .code_err  (code_err),
    .ovf_err   (ovf_err)
  );

  always #5 clk_59m = ~clk_59m;

  int          n_chk = 0;
  int          n_pass = 0;
  bit          gap_en = 1'b0;
  logic [31:0] sent[$];
  logic [31:0] pv_q[$];
  int          n_hs = 0, n_cerr = 0, n_ovf = 0;
  int          base, hb, cb, ob, exp_line;

  // Monitor pulses away from the active edge
  always @(negedge clk_59m) begin
    if (pix_valid) pv_q.push_back(pix_data);
    if (hs)        n_hs   <= n_hs + 1;
    if (code_err)  n_cerr <= n_cerr + 1;
    if (ovf_err)   n_ovf  <= n_ovf + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rb();
    return 8'($urandom_range(1, 254));
  endfunction

  task automatic put(input logic [7:0] b);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_59m); #1;
        din_valid = 1'b0;
        din = 8'($urandom);
      end
    end
    @(posedge clk_59m); #1;
    din = b;
    din_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_59m); #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic code(input logic [7:0] xy);
    put(8'hFF); put(8'h00); put(8'h00); put(xy);
  endtask

  task automatic send_quads(input int nq, input bit fixed);
    logic [31:0] w;
    for (int i = 0; i < nq; i++) begin
      w = fixed ? 32'h10203040 : {rb(), rb(), rb(), rb()};
      sent.push_back(w);
      for (int k = 3; k >= 0; k--) put(w[k*8 +: 8]);
    end
  endtask

  task automatic mark();
    base = pv_q.size(); hb = n_hs; cb = n_cerr; ob = n_ovf;
  endtask

  // Expected emission: the first n_exp quads sent since the SAV
  task automatic check_words(input string tag, input int n_exp);
    check({tag, "_count"}, pv_q.size() - base, n_exp);
    for (int i = 0; i < n_exp && base + i < pv_q.size(); i++)
      check({tag, "_word"}, pv_q[base + i], sent[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_hs"}, hs, 0);
    check({tag, "_vs"}, vs, 0);
    check({tag, "_field"}, field, 0);
    check({tag, "_line_cnt"}, line_cnt, 0);
    check({tag, "_pair_cnt"}, pair_cnt, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_code_err"}, code_err, 0);
    check({tag, "_ovf_err"}, ovf_err, 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk_59m);
    @(negedge clk_59m);
    check_zero("rst");
    #1 rst = 1'b0;

    // Clean line, fixed quads, with first-pair latency probe
    sent.delete(); mark();
    code(8'h80);
    send_quads(1, 1'b1);
    @(posedge clk_59m); #1 din_valid = 1'b0;
    @(negedge clk_59m);
    check("lat_pix_valid", pix_valid, 1);
    check("lat_pix_data", pix_data, 32'h10203040);
    send_quads(359, 1'b1);
    idle(2);
    check("clean_active", active, 1);
    check("clean_pair_pre_eav", pair_cnt, 360);
    code(8'h9D);
    idle(3);
    exp_line = 1;
    check_words("clean", 360);
    check("clean_hs", n_hs - hb, 1);
    check("clean_active_off", active, 0);
    check("clean_line", line_cnt, exp_line);
    check("clean_pair", pair_cnt, 360);
    check("clean_locked", locked, 1);
    check("clean_ovf", n_ovf - ob, 0);

    // Protection error in the middle of an active line
    sent.delete(); mark();
    code(8'h80);
    send_quads(4, 1'b0);
    code(8'h81);
    idle(3);
    check("perr_code_err", n_cerr - cb, 1);
    check("perr_locked", locked, 0);
    check("perr_active", active, 1);
    check("perr_vs", vs, 0);
    check("perr_field", field, 0);
    send_quads(2, 1'b0);
    idle(3);
    check_words("perr", 4);
    code(8'h9D);
    idle(3);
    exp_line = 2;
    check("perr_relock", locked, 1);
    check("perr_line", line_cnt, exp_line);
    check("perr_pair", pair_cnt, 4);
    check("perr_hs", n_hs - hb, 1);

    // Overflow: one quad beyond the active width
    sent.delete(); mark();
    code(8'h80);
    send_quads(361, 1'b0);
    code(8'h9D);
    idle(3);
    exp_line = 3;
    check_words("ovf", 360);
    check("ovf_pulses", n_ovf - ob, 1);
    check("ovf_pair", pair_cnt, 360);
    check("ovf_line", line_cnt, exp_line);

    // Blanking line, then V falling clears the line index
    sent.delete(); mark();
    code(8'hAB);
    send_quads(10, 1'b0);
    idle(2);
    check("blank_active", active, 0);
    check("blank_vs", vs, 1);
    check("blank_count", pv_q.size() - base, 0);
    code(8'hB6);
    idle(2);
    check("blank_line_hold", line_cnt, exp_line);
    check("blank_hs", n_hs - hb, 1);
    sent.delete(); mark();
    code(8'h80);
    idle(2);
    exp_line = 0;
    check("vfall_line", line_cnt, exp_line);
    check("vfall_vs", vs, 0);
    check("vfall_active", active, 1);
    send_quads(5, 1'b0);
    code(8'h9D);
    idle(3);
    exp_line = 1;
    check_words("vfall", 5);
    check("vfall_line_inc", line_cnt, exp_line);

    // Line index saturation with empty active lines
    for (int i = 0; i < 1030; i++) begin
      code(8'h80);
      code(8'h9D);
    end
    idle(2);
    check("sat_line", line_cnt, 10'h3FF);

    // Field toggle clears the line index
    code(8'hC7);
    idle(2);
    exp_line = 0;
    check("ftog_field", field, 1);
    check("ftog_line", line_cnt, exp_line);
    code(8'hDA);
    idle(2);
    exp_line = 1;
    check("ftog_line_inc", line_cnt, exp_line);

    // Gaps, truncated preamble and a dangling partial quad
    gap_en = 1'b1;
    sent.delete(); mark();
    code(8'hC7);
    send_quads(5, 1'b0);
    put(rb()); put(rb());
    put(8'hFF); put(8'h00); put(8'h55);
    send_quads(5, 1'b0);
    put(rb());
    code(8'hDA);
    idle(3);
    gap_en = 1'b0;
    exp_line = 2;
    check_words("gap", 10);
    check("gap_code_err", n_cerr - cb, 0);
    check("gap_ovf", n_ovf - ob, 0);
    check("gap_pair", pair_cnt, 10);
    check("gap_line", line_cnt, exp_line);
    check("gap_locked", locked, 1);

    // Asynchronous reset mid-line
    sent.delete();
    code(8'h80);
    send_quads(3, 1'b0);
    put(rb());
    @(negedge clk_59m); #2 rst = 1'b1;
    #1 check_zero("arst");
    repeat (2) @(posedge clk_59m);
    #1 rst = 1'b0;
    din_valid = 1'b0;
    mark();
    send_quads(3, 1'b0);
    idle(3);
    check("arst_no_pix", pv_q.size() - base, 0);
    check("arst_unlocked", locked, 0);
    sent.delete(); mark();
    code(8'h80);
    send_quads(2, 1'b0);
    code(8'h9D);
    idle(3);
    check_words("arst_resume", 2);
    check("arst_line", line_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bt656_rx.md
Name: bt656_rx

Overview:
- Receive-side counterpart of the ADV7179 encoder output path.
- Accepts an 8-bit ITU-R BT.656 byte stream from the video decoder (AD1 path) and locks onto the embedded FF 00 00 XY timing codes (SAV/EAV).
- Recovers H/V/F timing and unpacks 4:2:2 samples into Cb-Y0-Cr-Y1 pixel-pair words with a valid strobe.
- Feeds the frame buffer/processing chain that later drives the encoder.

Parameters:
- ACTIVE_PAIRS, 360, pixel pairs expected per active line (720 px).
- LINE_W, 10, width of the line counter.
- PAIR_W, 9, width of the pixel-pair counter.

Ports:
- clk_59m  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- din  in  8  BT.656 byte.
- din_valid  in  1  byte qualifier; din is sampled only when this is 1.
- pix_data  out  32  {Cb,Y0,Cr,Y1}, Cb in [31:24].
- pix_valid  out  1  one-cycle strobe per completed pair.
- active  out  1  high between SAV(V=0) and EAV.
- hs  out  1  one-cycle pulse on each valid EAV.
- vs  out  1  registered V bit of the last valid code.
- field  out  1  registered F bit of the last valid code.
- line_cnt  out  LINE_W  active line index within the field.
- pair_cnt  out  PAIR_W  pairs received in the current line.
- locked  out  1  set on the first valid code; cleared by reset or a code error.
- code_err  out  1  one-cycle pulse on a protection-bit mismatch.
- ovf_err  out  1  one-cycle pulse when a pair beyond ACTIVE_PAIRS arrives.

Behaviour:
- Reset: all outputs are 0 and the state machine goes to SEARCH.
  - Reset mid-line discards any partial pair and all counters.
- Clock gating: every state transition and capture happens only on cycles with din_valid=1. Cycles with din_valid=0 hold all state.
- Timing-code FSM states: SEARCH, P1 (FF seen), P2 (FF 00 seen), P3 (FF 00 00 seen), DATA.
  - SEARCH: FF -> P1.
  - P1: 00 -> P2; FF -> stay in P1; any other byte -> SEARCH, or DATA if locked.
  - P2: 00 -> P3; FF -> P1; any other byte -> SEARCH, or DATA if locked.
  - P3: the byte is XY = {1,F,V,H,P3,P2,P1,P0}.
- XY check:
  - Required: bit7=1, P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - Mismatch: pulse code_err, clear locked, leave vs/field/active unchanged, go to SEARCH.
- Valid XY:
  - Set locked and register vs<=V and field<=F.
  - H=1 (EAV): hs pulses, active<=0, next state SEARCH. If the closed line was active, line_cnt increments (saturating at all-ones).
  - H=0 (SAV): active<=~V, pair_cnt<=0, chroma phase<=0, next state DATA.
- line_cnt is cleared when a valid code shows V falling 1->0 or F toggling.
- DATA: bytes are captured in phase order Cb, Y0, Cr, Y1 (2-bit phase counter, wraps after Y1).
  - An FF byte is never captured: it goes to P1 and resets the phase, discarding the partial quad.
- Pair output: the cycle after the Y1 byte is sampled, pix_data is updated, pix_valid=1 for one cycle, and pair_cnt increments. Latency is 1 cycle from Y1 sample to strobe.
- pix_valid is only produced while active=1. Blanking-interval data is parsed but not emitted.
- Overflow: when pair_cnt is already ACTIVE_PAIRS, a further pair pulses ovf_err instead of pix_valid and pair_cnt holds.
- Short lines raise no error; the pair_cnt value at EAV is left visible until the next SAV.
- A valid EAV received while in DATA discards any partial quad and raises no error.

Decomposition:
- Shared package bt656_pkg holds:
  - localparams for the preamble bytes (FF, 00);
  - XY bit positions;
  - FSM state encodings;
  - a protection-check function shared with the encoder-side code generator.
- One sub-module, bt656_xy_check: combinational XY decode plus protection check, outputs F/V/H/ok, reusable by the transmit side.

Test Plan:
- Clean line, stream FF 00 00 80 (SAV, F=0 V=0), then 360 quads 10 20 30 40, then FF 00 00 9D (EAV) -> 360 pix_valid strobes with pix_data=32'h10203040; active=1 until EAV; one hs pulse; line_cnt=1; pair_cnt=360.
- Protection error, XY=8'h81 (bad P0) after a preamble -> code_err pulse, locked=0, vs/field/active unchanged, no pix_valid.
- Overflow, 361 quads between SAV and EAV -> 360 pix_valid pulses, one ovf_err pulse, pair_cnt=360.
- Blanking line, SAV with V=1 (XY=8'hAB) then quads -> active=0, no pix_valid, vs=1; then SAV with V=0 -> line_cnt cleared to 0.
- Gaps and truncated preamble, random din_valid=0 gaps during a clean line -> identical output to the gap-free case. The sequence FF 00 55 mid-DATA -> partial quad dropped, no error, capture resumes.
- Async reset asserted mid-line -> all outputs 0 immediately. After release, no pix_valid until a new valid SAV.
